vector_normaliser: RTL and testbench

Parametrised, handshaked fixed-point vector normaliser for the attitude-sensor pipeline. It generalises the fixed four-element quaternion normaliser to any element count and width. It replaces the start/done pulse pair with valid/ready on both sides, flags zero-magnitude inputs explicitly, and computes the result with an internal bit-serial square root and divider, so no external inverse-sqrt core is needed. It normalises the quaternion, the gradient step and the accel/mag vectors inside the Madgwick filter.

---
 rtl/vector_normaliser_if.sv | 22 ++
 rtl/vector_normaliser.sv | 221 ++++++++++++++++++++++
 tb/tb_vector_normaliser.sv | 127 ++++++++++++
 3 files changed

// File: rtl/vector_normaliser_if.sv
// Handshake bundle for vector_normaliser: the input vector stream and the normalised output stream.
interface vector_normaliser_if #(
    parameter int unsigned NUM_ELEM = 4,
    parameter int unsigned ELEM_W   = 16
);
    logic                       in_valid;
    logic                       in_ready;
    logic [NUM_ELEM*ELEM_W-1:0] in_data;
    logic                       out_valid;
    logic                       out_ready;
    logic [NUM_ELEM*ELEM_W-1:0] out_data;
    logic                       out_zero_mag;

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data, out_zero_mag
    );
    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data, out_zero_mag
    );
endinterface

// File: rtl/vector_normaliser.sv
// Fixed-point vector normaliser: serial sum of squares, restoring square root and
// per-element restoring division with round-half-up and saturation.
module vector_normaliser #(
    parameter int unsigned NUM_ELEM          = 4,
    parameter int unsigned INPUT_INT_WIDTH   = 2,
    parameter int unsigned INPUT_FRACT_WIDTH = 14
) (
    input  logic               clk,
    input  logic               rst_n,
    vector_normaliser_if.slave bus,
    output logic               busy
);
    localparam int unsigned W    = INPUT_INT_WIDTH + INPUT_FRACT_WIDTH;
    localparam int unsigned F    = INPUT_FRACT_WIDTH;
    localparam int unsigned SW   = 2 * W + $clog2(NUM_ELEM);
    localparam int unsigned R    = (SW + 1) / 2;
    localparam int unsigned D    = W + 1;
    localparam int unsigned RemW = R + 3;
    localparam int unsigned NW   = W + F + 1;
    localparam int unsigned EW   = $clog2(NUM_ELEM);
    localparam int unsigned CW   = $clog2(R);

    localparam logic [CW-1:0] RLast  = CW'(R - 1);
    localparam logic [CW-1:0] DLast  = CW'(D - 1);
    localparam logic [EW-1:0] ELast  = EW'(NUM_ELEM - 1);
    localparam logic [D:0]    MaxMag = {3'b000, {(W - 1){1'b1}}};

    typedef enum logic [2:0] {StIdle, StSqsum, StSqrt, StDiv, StOut} state_e;

    state_e          state_q, state_d;
    logic [W-1:0]    elem_q [NUM_ELEM];
    logic [W-1:0]    elem_d [NUM_ELEM];
    logic [W-1:0]    res_q  [NUM_ELEM];
    logic [W-1:0]    res_d  [NUM_ELEM];
    logic [SW-1:0]   acc_q, acc_d;
    logic [2*R-1:0]  s_q, s_d;
    logic [RemW-1:0] rem_q, rem_d;
    logic [R-1:0]    root_q, root_d;
    logic [R:0]      dr_q, dr_d;
    logic [D-1:0]    dsh_q, dsh_d;
    logic [D-1:0]    quo_q, quo_d;
    logic [EW-1:0]   eidx_q, eidx_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            zero_q, zero_d;

    logic signed [W-1:0]   sq_op;
    logic signed [2*W-1:0] sq;
    logic [RemW-1:0]       rem_sh, trial;
    logic [R:0]            dr_sh;
    logic                  qbit, load_div;
    logic [D:0]            q_rnd;
    logic [W-1:0]          mag_w, x_sel, x_mag;
    logic [NW-1:0]         dvd;
    logic [NUM_ELEM*W-1:0] out_pack;

    always_comb begin
        state_d  = state_q;
        elem_d   = elem_q;
        res_d    = res_q;
        acc_d    = acc_q;
        s_d      = s_q;
        rem_d    = rem_q;
        root_d   = root_q;
        dr_d     = dr_q;
        dsh_d    = dsh_q;
        quo_d    = quo_q;
        eidx_d   = eidx_q;
        cnt_d    = cnt_q;
        zero_d   = zero_q;
        sq_op    = '0;
        sq       = '0;
        rem_sh   = '0;
        trial    = '0;
        dr_sh    = '0;
        qbit     = 1'b0;
        load_div = 1'b0;
        q_rnd    = '0;
        mag_w    = '0;
        x_sel    = '0;
        x_mag    = '0;
        dvd      = '0;

        case (state_q)
            StIdle: begin
                if (bus.in_valid) begin
                    for (int i = 0; i < NUM_ELEM; i++) begin
                        elem_d[i] = bus.in_data[(NUM_ELEM-1-i)*W +: W];
                    end
                    acc_d   = '0;
                    eidx_d  = '0;
                    zero_d  = 1'b0;
                    state_d = StSqsum;
                end
            end
            StSqsum: begin
                sq_op  = signed'(elem_q[eidx_q]);
                sq     = sq_op * sq_op;
                acc_d  = acc_q + {{(SW - 2 * W){1'b0}}, sq};
                eidx_d = eidx_q + EW'(1);
                if (eidx_q == ELast) begin
                    eidx_d = '0;
                    if (acc_d == '0) begin
                        for (int i = 0; i < NUM_ELEM; i++) res_d[i] = '0;
                        zero_d  = 1'b1;
                        state_d = StOut;
                    end else begin
                        s_d             = '0;
                        s_d[SW-1:0]     = acc_d;
                        rem_d           = '0;
                        root_d          = '0;
                        cnt_d           = '0;
                        state_d         = StSqrt;
                    end
                end
            end
            StSqrt: begin
                rem_sh = (rem_q << 2) | RemW'(s_q[2*R-1 -: 2]);
                trial  = (RemW'(root_q) << 2) | RemW'(1);
                s_d    = s_q << 2;
                if (rem_sh >= trial) begin
                    rem_d  = rem_sh - trial;
                    root_d = (root_q << 1) | R'(1);
                end else begin
                    rem_d  = rem_sh;
                    root_d = root_q << 1;
                end
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == RLast) begin
                    cnt_d    = '0;
                    eidx_d   = '0;
                    load_div = 1'b1;
                    state_d  = StDiv;
                end
            end
            StDiv: begin
                dr_sh = (dr_q << 1) | (R + 1)'(dsh_q[D-1]);
                qbit  = (dr_sh >= {1'b0, root_q});
                dr_d  = qbit ? dr_sh - {1'b0, root_q} : dr_sh;
                dsh_d = dsh_q << 1;
                quo_d = (quo_q << 1) | D'(qbit);
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == DLast) begin
                    cnt_d = '0;
                    // Quotient carries one extra fraction bit, used for round half up.
                    q_rnd = ({1'b0, quo_d} + (D + 1)'(1)) >> 1;
                    if (q_rnd > MaxMag) q_rnd = MaxMag;
                    mag_w = q_rnd[W-1:0];
                    res_d[eidx_q] = elem_q[eidx_q][W-1] ? (~mag_w + W'(1)) : mag_w;
                    if (eidx_q == ELast) begin
                        state_d = StOut;
                    end else begin
                        eidx_d   = eidx_q + EW'(1);
                        load_div = 1'b1;
                    end
                end
            end
            StOut: begin
                if (bus.out_ready) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase

        if (load_div) begin
            x_sel = elem_q[eidx_d];
            // Two's complement negate maps the most negative code onto 2^(W-1) unsigned.
            x_mag = x_sel[W-1] ? (~x_sel + W'(1)) : x_sel;
            dvd   = {x_mag, {(F + 1){1'b0}}};
            dr_d  = '0;
            dr_d[F-1:0] = dvd[NW-1:D];
            dsh_d = dvd[D-1:0];
            quo_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            for (int i = 0; i < NUM_ELEM; i++) begin
                elem_q[i] <= '0;
                res_q[i]  <= '0;
            end
            acc_q  <= '0;
            s_q    <= '0;
            rem_q  <= '0;
            root_q <= '0;
            dr_q   <= '0;
            dsh_q  <= '0;
            quo_q  <= '0;
            eidx_q <= '0;
            cnt_q  <= '0;
            zero_q <= 1'b0;
        end else begin
            state_q <= state_d;
            elem_q  <= elem_d;
            res_q   <= res_d;
            acc_q   <= acc_d;
            s_q     <= s_d;
            rem_q   <= rem_d;
            root_q  <= root_d;
            dr_q    <= dr_d;
            dsh_q   <= dsh_d;
            quo_q   <= quo_d;
            eidx_q  <= eidx_d;
            cnt_q   <= cnt_d;
            zero_q  <= zero_d;
        end
    end

    always_comb begin
        out_pack = '0;
        for (int i = 0; i < NUM_ELEM; i++) begin
            out_pack[(NUM_ELEM-1-i)*W +: W] = res_q[i];
        end
    end

    assign bus.out_data     = out_pack;
    assign bus.out_valid    = (state_q == StOut);
    assign bus.out_zero_mag = zero_q;
    assign bus.in_ready     = (state_q == StIdle);
    assign busy             = (state_q != StIdle);
endmodule

// File: tb/tb_vector_normaliser.sv
// Directed bench for vector_normaliser: hand-computed vectors, latency, backpressure and abort.
module tb_vector_normaliser;
    localparam int unsigned N = 4;
    localparam int unsigned W = 16;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    logic busy;
    int   n_checks = 0;
    int   n_errors = 0;

    vector_normaliser_if #(.NUM_ELEM(N), .ELEM_W(W)) bus ();

    vector_normaliser #(
        .NUM_ELEM         (N),
        .INPUT_INT_WIDTH  (2),
        .INPUT_FRACT_WIDTH(14)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus),
        .busy (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic run_vec(input string tag, input logic [63:0] vin, input logic [63:0] vexp,
                           input logic zexp, input int lat, input int hold);
        int cyc = 0;
        @(negedge clk);
        bus.out_ready = (hold == 0);
        bus.in_valid  = 1'b1;
        bus.in_data   = vin;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        bus.in_data  = {$urandom, $urandom};
        do begin
            @(posedge clk);
            cyc++;
            @(negedge clk);
        end while (!bus.out_valid && cyc < 200);
        check({tag, " latency"}, 64'(cyc), 64'(lat));
        check({tag, " data"}, bus.out_data, vexp);
        check({tag, " zero_mag"}, 64'(bus.out_zero_mag), 64'(zexp));
        check({tag, " in_ready low"}, 64'(bus.in_ready), 64'd0);
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            check({tag, " hold valid"}, 64'(bus.out_valid), 64'd1);
            check({tag, " hold data"}, bus.out_data, vexp);
            check({tag, " hold in_ready"}, 64'(bus.in_ready), 64'd0);
        end
        bus.out_ready = 1'b1;
        @(negedge clk);
        check({tag, " valid drop"}, 64'(bus.out_valid), 64'd0);
        check({tag, " in_ready back"}, 64'(bus.in_ready), 64'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1);
    end

    initial begin
        int seen;
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.out_ready = 1'b0;
        #12;
        check("reset in_ready", 64'(bus.in_ready), 64'd1);
        check("reset out_valid", 64'(bus.out_valid), 64'd0);
        check("reset busy", 64'(busy), 64'd0);
        check("reset out_data", bus.out_data, 64'd0);
        check("reset zero_mag", 64'(bus.out_zero_mag), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;

        run_vec("defaults", 64'h0000_FE10_FF98_0000, 64'h0000_C144_F2D9_0000, 1'b0, 89, 0);
        run_vec("exact_root", 64'h3000_4000_0000_0000, 64'h2666_3333_0000_0000, 1'b0, 89, 0);
        run_vec("unit", 64'h4000_0000_0000_0000, 64'h4000_0000_0000_0000, 1'b0, 89, 0);
        run_vec("most_neg", 64'h8000_0000_0000_0000, 64'hC000_0000_0000_0000, 1'b0, 89, 0);
        run_vec("mixed_sign", 64'h2000_E000_2000_E000, 64'h2000_E000_2000_E000, 1'b0, 89, 0);
        run_vec("zero", 64'h0, 64'h0, 1'b1, 4, 0);
        run_vec("tiny_neg", 64'h0000_0000_0000_FFFF, 64'h0000_0000_0000_C000, 1'b0, 89, 0);
        run_vec("backpressure", 64'h0000_FE10_FF98_0000, 64'h0000_C144_F2D9_0000, 1'b0, 89, 10);

        // Abort mid-DIV: element 0 has already been written by cycle 40.
        @(negedge clk);
        bus.out_ready = 1'b1;
        bus.in_valid  = 1'b1;
        bus.in_data   = 64'h3000_4000_0000_0000;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        repeat (40) @(posedge clk);
        #2;
        check("abort busy before", 64'(busy), 64'd1);
        rst_n = 1'b0;
        #1;
        check("abort busy", 64'(busy), 64'd0);
        check("abort in_ready", 64'(bus.in_ready), 64'd1);
        check("abort out_valid", 64'(bus.out_valid), 64'd0);
        check("abort out_data", bus.out_data, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        seen = 0;
        repeat (100) begin
            @(negedge clk);
            if (bus.out_valid) seen++;
        end
        check("abort no output", 64'(seen), 64'd0);

        run_vec("after_abort", 64'h3000_4000_0000_0000, 64'h2666_3333_0000_0000, 1'b0, 89, 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
